iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Parametrised, multi-cycle barrel-shift unit for the RISC execute stage.
- Generalises shift-amount selection: register (rt) versus immediate (sh) amount, plus the over-range bypass.
- Supports four shift modes and shifts at most STEP bits per cycle, trading latency for area.
- Sits between the ALU operand muxes and the writeback mux, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, datapath and rt operand width; power of two, ≥8.
- SHW, $clog2(WIDTH) = 5, shift-amount field width.
- STEP, 4, maximum bits shifted per SHIFT cycle; power of two, 1..WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- data  input  WIDTH  operand to shift.
- rt  input  WIDTH  register shift-amount operand.
- sh  input  SHW  immediate shift amount.
- reg_imm  input  1  1 = amount from rt, 0 = amount from sh.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  shifted value.
- byp  output  1  result produced by over-range bypass; qualified by out_valid.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, byp=0, internal remaining-count=0.
- Amount select: amt = reg_imm ? rt[SHW-1:0] : sh.
- Over-range detect: ovr = reg_imm & |rt[WIDTH-1:SHW]. Immediate amounts are never over-range.
- Bypass value when ovr and op is not ROR:
  - SLL/SRL: all zeros.
  - SRA: WIDTH copies of data[WIDTH-1].
  - Set byp=1.
- ROR never bypasses: it rotates by amt (that is, rt mod WIDTH), with byp=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture data, op and amt.
  - If ovr (non-ROR): load the bypass value and go to DONE.
  - Else if amt==0: load data unchanged and go to DONE.
  - Else: rem=amt and go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle, k=min(rem,STEP); shift the working register by k per op, then rem-=k.
  - SRA fills with the captured sign bit; ROR wraps LSBs into the MSBs.
  - When rem-k==0, go to DONE on the same edge.
- DONE:
  - out_valid=1; result and byp are stable.
  - On out_ready, go to IDLE and drop out_valid on that edge.
  - No new request is accepted until IDLE (no overlap).
- Latency, counted from the accept edge to the first cycle with out_valid=1: 1 + ceil(amt/STEP) cycles.
  - Bypass and amt==0 take 1 cycle.
  - amt=31 with STEP=4 takes 9 cycles.
- Back-pressure: while DONE and out_ready=0, result, byp and out_valid hold indefinitely.
- Inputs are sampled only on the accept edge; changes to data, rt, sh, op or reg_imm afterwards have no effect.
- Reset mid-operation (SHIFT or DONE): abort immediately to the reset values; the in-flight result is discarded.
- STEP==WIDTH degenerates to a single-cycle shift: latency is 2 for any nonzero amount.

Decomposition:
- Shared package shifter_pkg holds:
  - op encodings: SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11;
  - the state enum {IDLE, SHIFT, DONE};
  - the STEP default.
- One natural sub-module: sh_amount_sel (combinational). It produces amt and ovr from rt, sh and reg_imm, parametrised by WIDTH/SHW.
- The step shifter (0..STEP-bit shift per op) stays inline.

Test Plan:
- SLL, reg_imm=0, sh=12, data=0x0000_00F1, STEP=4 -> out_valid 4 cycles after accept, result=0x000F_1000, byp=0.
- SRA, reg_imm=1, rt=0x0000_0040, data=0x8000_0000 -> 1-cycle bypass, result=0xFFFF_FFFF, byp=1. Same with SRL -> result=0, byp=1.
- ROR, reg_imm=1, rt=0x0000_0024 (mod 32 = 4), data=0x1234_5678 -> result=0x8123_4567, byp=0, latency 2.
- amt=0 (sh=0), data=0xDEAD_BEEF -> result=0xDEAD_BEEF after 1 cycle. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
- SRA, sh=31, data=0x8000_0000 -> result=0xFFFF_FFFF after 9 cycles. Assert rst_n low at cycle 3 -> out_valid=0 and in_ready=1 immediately; a new request after reset completes correctly.
- Random op/amount/data sweep with random out_ready stalls, checked against a reference model for WIDTH=32 with STEP ∈ {1,4,32}, and WIDTH=16 with STEP=2.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: op encodings, FSM state
// type and the default per-cycle shift step.
package shifter_pkg;

    // Shift operation encodings carried on the op port.
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Default maximum number of bit positions moved per SHIFT cycle.
    localparam int STEP_DEFAULT = 4;

endpackage

// File: rtl/iter_shifter_sh_amount_sel.sv
// Shift-amount selection for the iterative shifter.
//
// Ports:
//   rt      - register operand; its low SHW bits are the register amount
//   sh      - immediate shift amount
//   reg_imm - 1 selects the register amount, 0 the immediate
//   amt     - selected amount (register amount is implicitly rt mod WIDTH)
//   ovr     - register amount is WIDTH or larger (any upper rt bit set);
//             immediates can never be over-range
module sh_amount_sel #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] rt,
    input  logic [SHW-1:0]   sh,
    input  logic             reg_imm,
    output logic [SHW-1:0]   amt,
    output logic             ovr
);

    assign amt = reg_imm ? rt[SHW-1:0] : sh;
    assign ovr = reg_imm & (|rt[WIDTH-1:SHW]);

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle barrel-shift unit. Accepts one request at a time over a
// valid/ready handshake, shifts the captured operand by at most STEP bits
// per cycle, then presents the result until the consumer takes it.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready - request handshake; ready only while idle
//   data                - operand to shift
//   rt, sh, reg_imm     - register / immediate amount and its selector
//   op                  - SLL, SRL, SRA or ROR (see shifter_pkg)
//   out_valid/out_ready - result handshake
//   result              - shifted value
//   byp                 - result came from the over-range bypass
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STEP  = STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] rt,
    input  logic [SHW-1:0]   sh,
    input  logic             reg_imm,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             byp
);

    // One extra bit so STEP==WIDTH is representable; rem never reaches it,
    // so in that case k is always the full remaining amount.
    localparam logic [SHW:0] STEP_V = STEP[SHW:0];

    state_t           state, state_nx;
    logic [SHW-1:0]   rem, rem_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic             byp_q, byp_nx;
    logic [1:0]       op_q, op_nx;
    logic             sign_q, sign_nx;

    logic [SHW-1:0]   amt;
    logic             ovr;
    logic [SHW-1:0]   k;

    sh_amount_sel #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_amount_sel (
        .rt      (rt),
        .sh      (sh),
        .reg_imm (reg_imm),
        .amt     (amt),
        .ovr     (ovr)
    );

    // Shift w by k (< WIDTH) positions. SRA fills from the sign captured at
    // accept time; ROR wraps the bits shifted out of the LSB end.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] w,
        input logic [SHW-1:0]   kk,
        input logic [1:0]       o,
        input logic             s
    );
        logic [WIDTH-1:0] fill;
        logic [SHW-1:0]   kinv;
        fill = ~({WIDTH{1'b1}} >> kk);
        kinv = -kk;  // WIDTH - kk modulo WIDTH
        case (o)
            SH_SLL:  step_shift = w << kk;
            SH_SRL:  step_shift = w >> kk;
            SH_SRA:  step_shift = (w >> kk) | (s ? fill : '0);
            default: step_shift = (w >> kk) | ((kk == '0) ? '0 : (w << kinv));
        endcase
    endfunction

    // k = min(rem, STEP)
    assign k = ({1'b0, rem} > STEP_V) ? STEP_V[SHW-1:0] : rem;

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        work_nx  = work;
        byp_nx   = byp_q;
        op_nx    = op_q;
        sign_nx  = sign_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_nx   = op;
                    sign_nx = data[WIDTH-1];
                    byp_nx  = 1'b0;
                    rem_nx  = '0;
                    if (ovr && (op != SH_ROR)) begin
                        work_nx  = (op == SH_SRA) ? {WIDTH{data[WIDTH-1]}} : '0;
                        byp_nx   = 1'b1;
                        state_nx = DONE;
                    end else if (amt == '0) begin
                        work_nx  = data;
                        state_nx = DONE;
                    end else begin
                        work_nx  = data;
                        rem_nx   = amt;
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_nx = step_shift(work, k, op_q, sign_q);
                rem_nx  = rem - k;
                if (rem == k) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            work   <= '0;
            byp_q  <= 1'b0;
            op_q   <= SH_SLL;
            sign_q <= 1'b0;
        end else begin
            state  <= state_nx;
            rem    <= rem_nx;
            work   <= work_nx;
            byp_q  <= byp_nx;
            op_q   <= op_nx;
            sign_q <= sign_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = work;
    assign byp       = byp_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: directed cases on a WIDTH=32/STEP=4 instance,
// then randomized sweeps on four configurations checked against a
// behavioural model.
module tb_iter_shifter;

    logic clk;
    int   n_chk;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Main instance: WIDTH=32, STEP=4
    // ------------------------------------------------------------------
    logic        m_rst_n;
    logic        m_in_valid, m_in_ready, m_reg_imm, m_out_valid, m_out_ready, m_byp;
    logic [31:0] m_data, m_rt, m_result;
    logic [4:0]  m_sh;
    logic [1:0]  m_opc;

    iter_shifter #(.WIDTH(32), .SHW(5), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (m_rst_n),
        .in_valid  (m_in_valid),
        .in_ready  (m_in_ready),
        .data      (m_data),
        .rt        (m_rt),
        .sh        (m_sh),
        .reg_imm   (m_reg_imm),
        .op        (m_opc),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .result    (m_result),
        .byp       (m_byp)
    );

    task automatic run_main(input string tag, input logic [31:0] d, input logic [31:0] r,
                            input logic [4:0] s, input logic ri, input logic [1:0] o,
                            input logic [31:0] er, input logic eb, input int el, input int stall);
        int lat;
        @(negedge clk);
        check_val({tag, "_rdy"}, 32'(m_in_ready), 32'd1);
        m_data = d; m_rt = r; m_sh = s; m_reg_imm = ri; m_opc = o; m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        // scramble operands: they must have been captured at accept
        m_data = $urandom; m_rt = $urandom; m_sh = 5'($urandom);
        m_reg_imm = 1'($urandom); m_opc = 2'($urandom);
        lat = 1;
        while (!m_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_vld"}, 32'(m_out_valid), 32'd1);
        check_val({tag, "_lat"}, 32'(lat), 32'(el));
        check_val({tag, "_res"}, m_result, er);
        check_val({tag, "_byp"}, 32'(m_byp), 32'(eb));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_res"}, m_result, er);
            check_val({tag, "_hold_vld"}, 32'(m_out_valid), 32'd1);
            check_val({tag, "_hold_rdy"}, 32'(m_in_ready), 32'd0);
        end
        @(negedge clk);
        m_out_ready = 1'b1;
        @(posedge clk); #1;
        m_out_ready = 1'b0;
        check_val({tag, "_drop"}, 32'(m_out_valid), 32'd0);
        check_val({tag, "_back"}, 32'(m_in_ready), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Randomized sweep instances
    // ------------------------------------------------------------------
    logic sw_rst_n;
    logic sweep_go;

    for (genvar g = 0; g < 4; g++) begin : sw
        localparam int W  = (g == 3) ? 16 : 32;
        localparam int S  = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 32 : 2;
        localparam int SW = $clog2(W);

        logic          in_valid, in_ready, reg_imm, out_valid, out_ready, byp;
        logic [W-1:0]  data, rt, result;
        logic [SW-1:0] sh;
        logic [1:0]    op;
        logic          done_f;

        iter_shifter #(.WIDTH(W), .SHW(SW), .STEP(S)) dut (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .data      (data),
            .rt        (rt),
            .sh        (sh),
            .reg_imm   (reg_imm),
            .op        (op),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .result    (result),
            .byp       (byp)
        );

        // Model: full amount taken from rt or sh; register amounts of W or
        // more bypass (except ROR, which rotates by the amount mod W).
        function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic [W-1:0] r,
                                                   input logic [SW-1:0] s, input logic ri,
                                                   input logic [1:0] o, output logic bp,
                                                   output int lat);
            logic [W-1:0] v;
            int a;
            bp = 1'b0;
            if (ri && (r >= W) && (o != 2'b11)) begin
                bp  = 1'b1;
                lat = 1;
                return (o == 2'b10 && d[W-1]) ? {W{1'b1}} : '0;
            end
            a   = ri ? int'(r % W) : int'(s);
            lat = 1 + (a + S - 1) / S;
            v   = d;
            case (o)
                2'b00:   v = d << a;
                2'b01:   v = d >> a;
                2'b10:   v = $signed(d) >>> a;
                default: for (int i = 0; i < a; i++) v = {v[0], v[W-1:1]};
            endcase
            return v;
        endfunction

        initial begin : run
            logic [W-1:0] er;
            logic         eb;
            int           el, lat, stall;
            done_f = 1'b0;
            in_valid = 1'b0; out_ready = 1'b0; reg_imm = 1'b0; op = 2'b00;
            data = '0; rt = '0; sh = '0;
            wait (sweep_go);
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                data    = W'($urandom);
                sh      = SW'($urandom);
                reg_imm = 1'($urandom);
                op      = 2'($urandom);
                case ($urandom_range(0, 2))
                    0:       rt = W'($urandom);
                    1:       rt = W'($urandom_range(0, W - 1));
                    default: rt = W'($urandom_range(W - 1, W + 1));
                endcase
                er = ref_model(data, rt, sh, reg_imm, op, eb, el);
                check_val($sformatf("s%0d_n%0d_rdy", g, n), 32'(in_ready), 32'd1);
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                data = W'($urandom); rt = W'($urandom); sh = SW'($urandom); op = 2'($urandom);
                lat = 1;
                while (!out_valid && lat < 200) begin
                    out_ready = 1'($urandom);  // ignored while shifting
                    @(posedge clk); #1;
                    lat++;
                end
                out_ready = 1'b0;
                check_val($sformatf("s%0d_n%0d_vld", g, n), 32'(out_valid), 32'd1);
                check_val($sformatf("s%0d_n%0d_lat", g, n), 32'(lat), 32'(el));
                check_val($sformatf("s%0d_n%0d_res", g, n), 32'(result), 32'(er));
                check_val($sformatf("s%0d_n%0d_byp", g, n), 32'(byp), 32'(eb));
                stall = $urandom_range(0, 3);
                repeat (stall) @(posedge clk);
                #1;
                check_val($sformatf("s%0d_n%0d_stall", g, n), 32'(result), 32'(er));
                @(negedge clk);
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                check_val($sformatf("s%0d_n%0d_drop", g, n), 32'(out_valid), 32'd0);
            end
            done_f = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence, then sweep, then summary
    // ------------------------------------------------------------------
    initial begin
        int t;
        n_chk = 0;
        n_bad = 0;
        sweep_go = 1'b0;
        m_rst_n = 1'b0; sw_rst_n = 1'b0;
        m_in_valid = 1'b0; m_out_ready = 1'b0; m_reg_imm = 1'b0; m_opc = 2'b00;
        m_data = '0; m_rt = '0; m_sh = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(m_in_ready), 32'd1);
        check_val("rst_out_valid", 32'(m_out_valid), 32'd0);
        check_val("rst_result", m_result, 32'd0);
        check_val("rst_byp", 32'(m_byp), 32'd0);
        @(negedge clk);
        m_rst_n = 1'b1; sw_rst_n = 1'b1;

        run_main("sll12", 32'h0000_00F1, 32'h0, 5'd12, 1'b0, 2'b00, 32'h000F_1000, 1'b0, 4, 0);
        run_main("sra_ovr", 32'h8000_0000, 32'h0000_0040, 5'd0, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b1, 1, 0);
        run_main("srl_ovr", 32'h8000_0000, 32'h0000_0040, 5'd0, 1'b1, 2'b01, 32'h0, 1'b1, 1, 0);
        run_main("sra_ovr_pos", 32'h7FFF_0000, 32'h0000_0020, 5'd0, 1'b1, 2'b10, 32'h0, 1'b1, 1, 0);
        run_main("sll_ovr", 32'hFFFF_FFFF, 32'h8000_0000, 5'd0, 1'b1, 2'b00, 32'h0, 1'b1, 1, 0);
        run_main("ror36", 32'h1234_5678, 32'h0000_0024, 5'd0, 1'b1, 2'b11, 32'h8123_4567, 1'b0, 2, 0);
        run_main("amt0", 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 2'b01, 32'hDEAD_BEEF, 1'b0, 1, 5);
        run_main("imm_big_rt", 32'h0000_0080, 32'hFFFF_FFFF, 5'd3, 1'b0, 2'b01, 32'h0000_0010, 1'b0, 2, 0);
        run_main("sll31", 32'h0000_0001, 32'h0, 5'd31, 1'b0, 2'b00, 32'h8000_0000, 1'b0, 9, 2);

        // Reset in the middle of a 9-cycle SRA
        @(negedge clk);
        m_data = 32'h8000_0000; m_sh = 5'd31; m_reg_imm = 1'b0; m_opc = 2'b10; m_in_valid = 1'b1;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check_val("mid_busy", 32'(m_in_ready), 32'd0);
        m_rst_n = 1'b0;
        #1;
        check_val("mid_rst_vld", 32'(m_out_valid), 32'd0);
        check_val("mid_rst_rdy", 32'(m_in_ready), 32'd1);
        check_val("mid_rst_res", m_result, 32'd0);
        @(negedge clk);
        m_rst_n = 1'b1;
        run_main("after_rst", 32'h0000_00F1, 32'h0, 5'd12, 1'b0, 2'b00, 32'h000F_1000, 1'b0, 4, 0);
        run_main("sra31", 32'h8000_0000, 32'h0, 5'd31, 1'b0, 2'b10, 32'hFFFF_FFFF, 1'b0, 9, 0);

        sweep_go = 1'b1;
        t = 0;
        while (!(sw[0].done_f && sw[1].done_f && sw[2].done_f && sw[3].done_f) && t < 40000) begin
            @(posedge clk);
            t++;
        end
        check_val("sweep_finished",
                  32'({sw[3].done_f, sw[2].done_f, sw[1].done_f, sw[0].done_f}), 32'hF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
